// File: rtl/sequence_display_pkg.sv
// Shared types and defaults for the PlaySeq sequence display stage.
package sequence_display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 4;

    // Counter must reach max(on,off)-1; never narrower than one bit.
    function automatic int tick_width(input int on_ticks, input int off_ticks);
        int longest;
        longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/sequence_display_tick_counter.sv
// Free-running tick counter with synchronous clear and a runtime terminal-count compare.
module tick_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/sequence_display.sv
// Walks the sequence ROM from 0 to a sampled limit and shows each value on the LEDs.
// Optional blank gap between values is enabled with `define SEQUENCE_DISPLAY_GAP_EN.
module sequence_display
    import sequence_display_pkg::*;
#(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] limit,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = tick_width(ON_TICKS, OFF_TICKS);
    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_TICKS - 1);
`ifdef SEQUENCE_DISPLAY_GAP_EN
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
`endif

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] limit_q;
    logic [ADDR_W-1:0] next_limit;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_leds;
    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  terminal;
    logic              at_terminal;

    tick_counter #(
        .WIDTH(CNT_W)
    ) u_tick_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .terminal   (terminal),
        .at_terminal(at_terminal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            leds     <= '0;
            limit_q  <= '0;
        end else begin
            state    <= next_state;
            rom_addr <= next_addr;
            leds     <= next_leds;
            limit_q  <= next_limit;
        end
    end

    always_comb begin
        next_state = state;
        next_addr  = rom_addr;
        next_leds  = leds;
        next_limit = limit_q;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        terminal   = ON_LAST;

        case (state)
            IDLE: begin
                if (start) begin
                    next_limit = limit;
                    next_addr  = '0;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = LOAD;
            end
            LOAD: begin
                next_leds  = rom_data;
                cnt_clear  = 1'b1;
                next_state = SHOW;
            end
            SHOW: begin
                cnt_en = 1'b1;
                if (at_terminal) begin
                    cnt_clear = 1'b1;
`ifdef SEQUENCE_DISPLAY_GAP_EN
                    next_leds  = '0;
                    next_state = GAP;
`else
                    // Without a gap the value stays lit until the next one loads.
                    if (rom_addr == limit_q) begin
                        next_leds  = '0;
                        next_state = DONE;
                    end else begin
                        next_addr  = rom_addr + ADDR_W'(1);
                        next_state = FETCH;
                    end
`endif
                end
            end
`ifdef SEQUENCE_DISPLAY_GAP_EN
            GAP: begin
                terminal = OFF_LAST;
                cnt_en   = 1'b1;
                if (at_terminal) begin
                    cnt_clear = 1'b1;
                    if (rom_addr == limit_q) begin
                        next_state = DONE;
                    end else begin
                        next_addr  = rom_addr + ADDR_W'(1);
                        next_state = FETCH;
                    end
                end
            end
`endif
            DONE: begin
                next_leds  = '0;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sequence_display.sv
// Randomized playback bench for sequence_display against a cycle-position reference model.
module tb_sequence_display;

    localparam int ON  = 4;
    localparam int OFF = 2;
`ifdef SEQUENCE_DISPLAY_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam int PERIOD = 2 + ON + (GAP_EN ? OFF : 0);

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] limit;
    logic [3:0] rom_data;
    logic [3:0] rom_addr;
    logic [3:0] leds;
    logic       busy;
    logic       done;

    logic [3:0] rom_table [0:15] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                                     4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8};

    int         total;
    int         bad;
    logic [3:0] prev_addr;

    sequence_display #(
        .ON_TICKS (ON),
        .OFF_TICKS(OFF),
        .ADDR_W   (4),
        .DATA_W   (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .limit   (limit),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) rom_data <= rom_table[rom_addr];

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Expected outputs c cycles after start was accepted, from step index and offset within a step.
    function automatic void expect_at(input int lim, input int c, output logic [3:0] e_leds,
                                      output logic e_done, output logic e_busy, output logic [3:0] e_addr);
        int end_c;
        int k;
        int o;
        end_c = 1 + (lim + 1) * PERIOD;
        e_busy = 1'b1;
        if (c == end_c) begin
            e_leds = 4'd0;
            e_done = 1'b1;
            e_addr = lim[3:0];
        end else begin
            k = (c - 1) / PERIOD;
            o = (c - 1) % PERIOD;
            e_done = 1'b0;
            e_addr = k[3:0];
            if (o >= 2 && o < 2 + ON) e_leds = rom_table[k];
            else if (GAP_EN) e_leds = 4'd0;
            else e_leds = (k == 0) ? 4'd0 : rom_table[k-1];
        end
    endfunction

    task automatic check_idle(input string tag);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_leds"}, 32'(leds), 32'd0);
        check_output({tag, "_addr"}, 32'(rom_addr), 32'(prev_addr));
    endtask

    task automatic check_cycle(input int lim, input int c);
        logic [3:0] el;
        logic [3:0] ea;
        logic       ed;
        logic       eb;
        expect_at(lim, c, el, ed, eb, ea);
        check_output($sformatf("leds_L%0d_c%0d", lim, c), 32'(leds), 32'(el));
        check_output($sformatf("done_L%0d_c%0d", lim, c), 32'(done), 32'(ed));
        check_output($sformatf("busy_L%0d_c%0d", lim, c), 32'(busy), 32'(eb));
        check_output($sformatf("addr_L%0d_c%0d", lim, c), 32'(rom_addr), 32'(ea));
    endtask

    // One playback run; start/limit are scrambled mid-run and must be ignored.
    task automatic apply_stimulus(input int lim, input int abort_c);
        int end_c;
        end_c = 1 + (lim + 1) * PERIOD;
        @(negedge clock);
        check_idle("idle");
        start = 1'b1;
        limit = lim[3:0];
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clock);
            check_cycle(lim, c);
            if (c == abort_c) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                prev_addr = 4'd0;
                check_idle("abort");
                repeat (2) begin
                    @(negedge clock);
                    check_idle("abort_hold");
                end
                reset_n = 1'b1;
                return;
            end
            if (c < end_c) begin
                start = 1'($urandom_range(0, 1));
                limit = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        prev_addr = lim[3:0];
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        prev_addr = 4'd0;
        reset_n   = 1'b0;
        start     = 1'b1;
        limit     = 4'd7;
        repeat (3) @(negedge clock);
        check_idle("reset_held");
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clock);
        check_idle("reset_rel");

        apply_stimulus(0, 0);
        apply_stimulus(15, 0);
        apply_stimulus(5, 0);
        apply_stimulus(3, 12);
        apply_stimulus(3, 0);
        repeat (6) apply_stimulus(int'($urandom_range(0, 15)), 0);
        @(negedge clock);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_display.md
# sequence_display

Playback stage for PlaySeq: on `start`, walks the synchronous 16x4 sequence ROM from address 0 up to a sampled `limit`, drives the ROM address, and shows each fetched one-hot value on the LEDs for a fixed on-time followed by a blank gap. It sits directly upstream of the sequence ROM's address input and downstream of its data output. It feeds the LED outputs and signals `done` to the game control unit when the display finishes.

## Interface
- `ON_TICKS`, 4, cycles each value is held on `leds` (>= 1)
- `OFF_TICKS`, 2, blank cycles after each value (>= 1; used only with gap feature)
- `ADDR_W`, 4, ROM address width
- `DATA_W`, 4, ROM data / LED width
- `clock`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin playback; honoured only in IDLE
- `limit`  in  ADDR_W  last address shown (inclusive); sampled when `start` is accepted
- `rom_data`  in  DATA_W  synchronous ROM output (valid one cycle after address is sampled)
- `rom_addr`  out  ADDR_W  registered ROM address
- `leds`  out  DATA_W  registered displayed value
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when playback completes

## Operation
- Reset (async, `reset_n`=0): state IDLE; `rom_addr`=0, `leds`=0, `busy`=0, `done`=0, tick counter=0, `limit_q`=0.
- States: IDLE, FETCH, LOAD, SHOW, GAP, DONE.
- IDLE: `start`=1 -> `limit_q`<=`limit`, `rom_addr`<=0, go FETCH.
- FETCH (1 cycle): `rom_addr` is stable; the ROM samples it on the closing edge. Go LOAD.
- LOAD (1 cycle): `leds`<=`rom_data` on the closing edge, tick counter<=0, go SHOW.
- SHOW (ON_TICKS cycles): `leds` holds the value. At count ON_TICKS-1: `leds`<=0, counter<=0, go GAP.
- GAP (OFF_TICKS cycles): `leds`=0. At count OFF_TICKS-1:
  - if `rom_addr`==`limit_q`, go DONE;
  - else `rom_addr`<=`rom_addr`+1 and go FETCH.
- DONE (1 cycle): `done`=1, `leds`=0, go IDLE; `rom_addr` retains its last value.
- Tick counter width: `$clog2(max(ON_TICKS,OFF_TICKS))`, minimum 1 bit.
- The address never wraps: the maximum `limit` is 2^ADDR_W-1, and the increment occurs only when `rom_addr`<`limit_q`.
- `start` outside IDLE is ignored. Changes on `limit` after acceptance are ignored.
- Async reset mid-playback returns immediately to the reset values. No `done` is emitted.

## Timing
- `start` sampled high at edge 0 -> FETCH in cycle 1 -> LOAD in cycle 2 -> `leds` valid from cycle 3.
- Per-step period: 2+ON_TICKS+OFF_TICKS cycles (8 at defaults).
- `done` is high in cycle 1+(limit+1)*period. IDLE follows on the next cycle, where a new `start` is accepted.
- `busy` rises in cycle 1 and falls with the return to IDLE (the cycle after `done`).

## Configuration
- `SEQUENCE_DISPLAY_GAP_EN` defined: GAP state present, as described above.
- `SEQUENCE_DISPLAY_GAP_EN` undefined:
  - GAP state removed; SHOW at count ON_TICKS-1 applies the GAP exit rules directly.
  - `leds` is cleared only when going to DONE.
  - OFF_TICKS is ignored; period = 2+ON_TICKS.

## Structure
- Shared package `sequence_display_pkg`: state enum (IDLE, FETCH, LOAD, SHOW, GAP, DONE), default ADDR_W/DATA_W constants.
- One sub-module: `tick_counter` (clear, enable, terminal-count compare against a runtime value).

## Test plan
All scenarios use a bench 16x4 synchronous ROM model with contents 1,1,1,1,2,2,2,2,4,4,4,4,8,8,8,8 and default parameters.
- Reset held, then released -> all outputs 0, IDLE; `start` pulse with `limit`=0 -> `leds`=0001 in cycles 3-6, 0 in cycles 7-8, `done` in cycle 9 only.
- `limit`=15 -> `rom_addr` 0..15 in order; `leds` sequence 1×4, 2×4, 4×4, 8×4; `done` in cycle 129; `rom_addr` stays 15.
- `start` re-pulsed in cycle 20, and `limit` changed 5->2 in cycle 4 -> both ignored; `done` in cycle 49 (limit 5).
- `reset_n` pulled low in cycle 12 of a `limit`=3 run -> outputs 0 asynchronously within the cycle, no `done`; a restart works normally.
- Built without `SEQUENCE_DISPLAY_GAP_EN`, `limit`=15 -> no blank cycles between values; `done` in cycle 97.
- `start` in the cycle right after `done` -> accepted; second run's FETCH follows immediately.
